// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake, saturating arithmetic,
// PADDSB lanes and a persistent {Z,V,N} flag register.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_op,
  output logic [2:0]       flags
);

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_XOR    = 3'b010,
    OP_RED    = 3'b011,
    OP_SLL    = 3'b100,
    OP_SRA    = 3'b101,
    OP_ROR    = 3'b110,
    OP_PADDSB = 3'b111
  } op_e;

  localparam int NBYTES = WIDTH / 8;
  localparam int NLANES = WIDTH / LANE;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE-1:0]  LANE_MAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0]  LANE_MIN = {1'b1, {(LANE-1){1'b0}}};

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  logic             advance;
  logic [SHW-1:0]   amt;
  logic [SHW:0]     rev_amt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] red_sum;
  logic [WIDTH-1:0] pad_sum;
  logic [WIDTH-1:0] ror_res;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             upd_z;
  logic             upd_vn;
  logic [2:0]       flags_next;

  // A held output blocks both stages; stage 1 may still fill if it is empty.
  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;

  function automatic logic [WIDTH-1:0] sext8(input logic [7:0] b);
    logic [WIDTH-1:0] r;
    r      = {WIDTH{b[7]}};
    r[7:0] = b;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= op_e'(in_op);
      end
    end
  end

  assign amt     = s1_b[SHW-1:0];
  assign rev_amt = (SHW+1)'(WIDTH) - {1'b0, amt};
  assign sum     = s1_a + s1_b;
  assign diff    = s1_a - s1_b;
  assign add_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
  assign sub_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);

  // Shifting left by WIDTH yields zero, so amt=0 degenerates to plain A.
  assign ror_res = (s1_a >> amt) | (s1_a << rev_amt);

  always_comb begin
    red_sum = '0;
    for (int i = 0; i < NBYTES; i++) begin
      red_sum = red_sum + sext8(s1_a[8*i +: 8]) + sext8(s1_b[8*i +: 8]);
    end
  end

  always_comb begin : paddsb
    logic [LANE-1:0] la;
    logic [LANE-1:0] lb;
    logic [LANE-1:0] ls;
    pad_sum = '0;
    la      = '0;
    lb      = '0;
    ls      = '0;
    for (int l = 0; l < NLANES; l++) begin
      la = s1_a[l*LANE +: LANE];
      lb = s1_b[l*LANE +: LANE];
      ls = la + lb;
      if ((la[LANE-1] == lb[LANE-1]) && (ls[LANE-1] != la[LANE-1])) begin
        ls = la[LANE-1] ? LANE_MIN : LANE_MAX;
      end
      pad_sum[l*LANE +: LANE] = ls;
    end
  end

  always_comb begin
    res    = '0;
    ovf    = 1'b0;
    upd_z  = 1'b0;
    upd_vn = 1'b0;
    case (s1_op)
      OP_ADD: begin
        ovf    = add_ovf;
        res    = add_ovf ? (s1_a[WIDTH-1] ? MIN_NEG : MAX_POS) : sum;
        upd_z  = 1'b1;
        upd_vn = 1'b1;
      end
      OP_SUB: begin
        ovf    = sub_ovf;
        res    = sub_ovf ? (s1_a[WIDTH-1] ? MIN_NEG : MAX_POS) : diff;
        upd_z  = 1'b1;
        upd_vn = 1'b1;
      end
      OP_XOR: begin
        res   = s1_a ^ s1_b;
        upd_z = 1'b1;
      end
      OP_RED:    res = red_sum;
      OP_SLL: begin
        res   = s1_a << amt;
        upd_z = 1'b1;
      end
      OP_SRA: begin
        res   = $signed(s1_a) >>> amt;
        upd_z = 1'b1;
      end
      OP_ROR: begin
        res   = ror_res;
        upd_z = 1'b1;
      end
      OP_PADDSB: res = pad_sum;
      default:   res = '0;
    endcase
  end

  // Flag order is {Z,V,N}; ops outside the update mask keep their old bits.
  always_comb begin
    flags_next = flags;
    if (upd_z) begin
      flags_next[2] = (res == '0);
    end
    if (upd_vn) begin
      flags_next[1] = ovf;
      flags_next[0] = res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_op     <= 3'b000;
      flags      <= 3'b000;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res;
        out_op     <= s1_op;
        flags      <= flags_next;
      end
    end
  end

endmodule
